// File: rtl/apb_addr_decode.sv
// -----------------------------------------------------------------------------
// apb_addr_decode
//
// 1-to-2 APB3 address decoder. One upstream completer port (apbReg) is steered
// to one of two downstream requester ports (apb_uBlockA / apb_uBlockB) by
// address. The selected target's response is returned upstream. Unmapped
// addresses complete locally with pslverr=1 and zero wait states.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   apbReg_*                   upstream APB completer port (paddr, psel, penable,
//                              pwrite, pwdata in; pready, prdata, pslverr out)
//   apb_uBlockA_*              downstream requester port to uBlockA
//   apb_uBlockB_*              downstream requester port to uBlockB
//
// Optional feature macro: APB_DECODE_TIMEOUT_EN
//   When defined, an A/B target that holds pready low for TIMEOUT_CYCLES
//   consecutive ACCESS cycles is abandoned: the decoder completes upstream with
//   pslverr=1, prdata=0 and drops the downstream psel/penable in that cycle.
//   When undefined, the decoder waits indefinitely for the target.
// -----------------------------------------------------------------------------
module apb_addr_decode #(
   parameter logic [31:0] BLOCKA_BASE    = 32'h0000_0000,
   parameter logic [31:0] BLOCKB_BASE    = 32'h0001_0000,
   parameter int unsigned REGION_LOG2    = 16,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   // upstream
   input  logic [31:0] apbReg_paddr,
   input  logic        apbReg_psel,
   input  logic        apbReg_penable,
   input  logic        apbReg_pwrite,
   input  logic [31:0] apbReg_pwdata,
   output logic        apbReg_pready,
   output logic [31:0] apbReg_prdata,
   output logic        apbReg_pslverr,
   // downstream A
   output logic [31:0] apb_uBlockA_paddr,
   output logic        apb_uBlockA_psel,
   output logic        apb_uBlockA_penable,
   output logic        apb_uBlockA_pwrite,
   output logic [31:0] apb_uBlockA_pwdata,
   input  logic        apb_uBlockA_pready,
   input  logic [31:0] apb_uBlockA_prdata,
   input  logic        apb_uBlockA_pslverr,
   // downstream B
   output logic [31:0] apb_uBlockB_paddr,
   output logic        apb_uBlockB_psel,
   output logic        apb_uBlockB_penable,
   output logic        apb_uBlockB_pwrite,
   output logic [31:0] apb_uBlockB_pwdata,
   input  logic        apb_uBlockB_pready,
   input  logic [31:0] apb_uBlockB_prdata,
   input  logic        apb_uBlockB_pslverr
);

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_A    = 2'd1,
      SEL_B    = 2'd2
   } sel_t;

   sel_t  selQ_r;
   sel_t  liveSel_s;
   sel_t  effSel_s;
   logic  hitA_s;
   logic  hitB_s;
   logic  setupPhase_s;
   logic  accessPhase_s;
   logic  timeoutHit_s;
   logic        upPready_s;
   logic [31:0] upPrdata_s;
   logic        upPslverr_s;

   // Region match on the bits above the naturally aligned region size.
   assign hitA_s = (apbReg_paddr[31:REGION_LOG2] == BLOCKA_BASE[31:REGION_LOG2]);
   assign hitB_s = (apbReg_paddr[31:REGION_LOG2] == BLOCKB_BASE[31:REGION_LOG2]);

   assign setupPhase_s  = apbReg_psel & ~apbReg_penable;
   assign accessPhase_s = apbReg_psel &  apbReg_penable;

   // Live decode; A has priority when both regions overlap.
   always_comb begin
      liveSel_s = SEL_NONE;
      if (hitA_s) begin
         liveSel_s = SEL_A;
      end else if (hitB_s) begin
         liveSel_s = SEL_B;
      end else begin
         liveSel_s = SEL_NONE;
      end
   end

   // SETUP uses the live decode; ACCESS uses the latched target so a moving
   // address mid-transfer cannot retarget the transfer.
   assign effSel_s = setupPhase_s ? liveSel_s : selQ_r;

   // Target select register: latch on SETUP, clear after completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         selQ_r <= SEL_NONE;
      end else if (setupPhase_s) begin
         selQ_r <= liveSel_s;
      end else if (accessPhase_s && upPready_s) begin
         selQ_r <= SEL_NONE;
      end else begin
         selQ_r <= selQ_r;
      end
   end

`ifdef APB_DECODE_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CNT_W-1:0] stallCnt_r;
   logic             tgtPready_s;
   logic             stalled_s;

   // pready of the latched target; NONE never stalls.
   always_comb begin
      tgtPready_s = 1'b1;
      case (selQ_r)
         SEL_A:   tgtPready_s = apb_uBlockA_pready;
         SEL_B:   tgtPready_s = apb_uBlockB_pready;
         default: tgtPready_s = 1'b1;
      endcase
   end

   assign stalled_s    = accessPhase_s & (selQ_r != SEL_NONE) & ~tgtPready_s;
   // stallCnt_r holds the number of earlier stalled ACCESS cycles, so the
   // limit is reached on the TIMEOUT_CYCLES-th stalled cycle itself.
   assign timeoutHit_s = stalled_s & (stallCnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

   // Consecutive-stall counter; clears on completion, timeout or idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCnt_r <= '0;
      end else if (stalled_s && !timeoutHit_s) begin
         stallCnt_r <= stallCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stallCnt_r <= '0;
      end
   end
`else
   assign timeoutHit_s = 1'b0;
`endif

   // Downstream gating; everything is forced low while in reset.
   assign apb_uBlockA_psel    = rst_n & apbReg_psel    & (effSel_s == SEL_A) & ~timeoutHit_s;
   assign apb_uBlockA_penable = rst_n & apbReg_penable & (effSel_s == SEL_A) & ~timeoutHit_s;
   assign apb_uBlockB_psel    = rst_n & apbReg_psel    & (effSel_s == SEL_B) & ~timeoutHit_s;
   assign apb_uBlockB_penable = rst_n & apbReg_penable & (effSel_s == SEL_B) & ~timeoutHit_s;

   // Address, direction and write data go to both ports unmodified.
   assign apb_uBlockA_paddr  = apbReg_paddr;
   assign apb_uBlockA_pwrite = apbReg_pwrite;
   assign apb_uBlockA_pwdata = apbReg_pwdata;
   assign apb_uBlockB_paddr  = apbReg_paddr;
   assign apb_uBlockB_pwrite = apbReg_pwrite;
   assign apb_uBlockB_pwdata = apbReg_pwdata;

   // Upstream response mux; only active in ACCESS, zero otherwise.
   always_comb begin
      upPready_s  = 1'b0;
      upPrdata_s  = 32'h0000_0000;
      upPslverr_s = 1'b0;
      if (rst_n && accessPhase_s) begin
         if (timeoutHit_s) begin
            upPready_s  = 1'b1;
            upPrdata_s  = 32'h0000_0000;
            upPslverr_s = 1'b1;
         end else begin
            case (selQ_r)
               SEL_A: begin
                  upPready_s  = apb_uBlockA_pready;
                  upPrdata_s  = apb_uBlockA_prdata;
                  upPslverr_s = apb_uBlockA_pslverr;
               end
               SEL_B: begin
                  upPready_s  = apb_uBlockB_pready;
                  upPrdata_s  = apb_uBlockB_prdata;
                  upPslverr_s = apb_uBlockB_pslverr;
               end
               SEL_NONE: begin
                  // unmapped: complete locally with an error, no wait states
                  upPready_s  = 1'b1;
                  upPrdata_s  = 32'h0000_0000;
                  upPslverr_s = 1'b1;
               end
               default: begin
                  upPready_s  = 1'b0;
                  upPrdata_s  = 32'h0000_0000;
                  upPslverr_s = 1'b0;
               end
            endcase
         end
      end else begin
         upPready_s  = 1'b0;
         upPrdata_s  = 32'h0000_0000;
         upPslverr_s = 1'b0;
      end
   end

   assign apbReg_pready  = upPready_s;
   assign apbReg_prdata  = upPrdata_s;
   assign apbReg_pslverr = upPslverr_s;

endmodule

// File: tb/tb_apb_addr_decode.sv
module tb_apb_addr_decode;

   localparam longint unsigned A_LO = 64'h0000_0000;
   localparam longint unsigned B_LO = 64'h0001_0000;
   localparam longint unsigned RSZ  = 64'h0001_0000;
`ifdef APB_DECODE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] paddr;
   logic        psel, penable, pwrite;
   logic [31:0] pwdata;
   logic        upPready, upPslverr;
   logic [31:0] upPrdata;
   logic [31:0] aPaddr, aPwdata, aPrdata, bPaddr, bPwdata, bPrdata;
   logic        aPsel, aPenable, aPwrite, aPready, aPslverr;
   logic        bPsel, bPenable, bPwrite, bPready, bPslverr;

   always #5 clk = ~clk;

   apb_addr_decode dut (
      .clk(clk), .rst_n(rst_n),
      .apbReg_paddr(paddr), .apbReg_psel(psel), .apbReg_penable(penable),
      .apbReg_pwrite(pwrite), .apbReg_pwdata(pwdata),
      .apbReg_pready(upPready), .apbReg_prdata(upPrdata), .apbReg_pslverr(upPslverr),
      .apb_uBlockA_paddr(aPaddr), .apb_uBlockA_psel(aPsel), .apb_uBlockA_penable(aPenable),
      .apb_uBlockA_pwrite(aPwrite), .apb_uBlockA_pwdata(aPwdata),
      .apb_uBlockA_pready(aPready), .apb_uBlockA_prdata(aPrdata), .apb_uBlockA_pslverr(aPslverr),
      .apb_uBlockB_paddr(bPaddr), .apb_uBlockB_psel(bPsel), .apb_uBlockB_penable(bPenable),
      .apb_uBlockB_pwrite(bPwrite), .apb_uBlockB_pwdata(bPwdata),
      .apb_uBlockB_pready(bPready), .apb_uBlockB_prdata(bPrdata), .apb_uBlockB_pslverr(bPslverr)
   );

   int nTests = 0;
   int nFail  = 0;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] rdata;
      logic        err;
      int          expTgt;   // 0 none, 1 A, 2 B
      logic        expErr;
      logic [31:0] expRdata;
   } vec_t;

   // Reference decode from address ranges; A checked first so it wins overlaps.
   function automatic int regionOf(input logic [31:0] a);
      longint unsigned ua;
      ua = a;
      if (ua >= A_LO && ua < A_LO + RSZ) return 1;
      if (ua >= B_LO && ua < B_LO + RSZ) return 2;
      return 0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic checkCycle(input string nm, input int selTgt, input logic en,
                             input logic rdy, input logic [31:0] rd, input logic err);
      logic [5:0] act;
      logic [5:0] exp;
      act = {aPsel, aPenable, bPsel, bPenable, upPready, upPslverr};
      exp = {selTgt == 1, en && selTgt == 1, selTgt == 2, en && selTgt == 2, rdy, err};
      chk({nm, " ctl"}, {26'd0, act}, {26'd0, exp});
      chk({nm, " prdata"}, upPrdata, rd);
      chk({nm, " fwd"}, (aPaddr ^ paddr) | (bPaddr ^ paddr) | (aPwdata ^ pwdata) |
          (bPwdata ^ pwdata) | {31'd0, (aPwrite ^ pwrite) | (bPwrite ^ pwrite)}, 32'd0);
   endtask

   task automatic randomizeResp();
      aPready = 1'($urandom_range(0, 1)); aPslverr = 1'($urandom_range(0, 1)); aPrdata = $urandom();
      bPready = 1'($urandom_range(0, 1)); bPslverr = 1'($urandom_range(0, 1)); bPrdata = $urandom();
   endtask

   task automatic idleCycle(input string nm);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      randomizeResp();
      #3 checkCycle(nm, 0, 1'b0, 1'b0, 32'd0, 1'b0);
   endtask

   // One full transfer; the bench plays the target, and tgt names the port
   // that is expected to be selected.
   task automatic doXfer(input string nm, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wd, input int waits, input logic [31:0] rd,
                         input logic err, input logic glitch, input logic [31:0] gAddr,
                         input int tgt, input logic expErr, input logic [31:0] expRd);
      int  acc;
      bit  done;
      bit  tRdy;
      bit  tout;
      @(posedge clk); #1;
      paddr = addr; pwrite = wr; pwdata = wd; psel = 1'b1; penable = 1'b0;
      randomizeResp();
      #3 checkCycle({nm, " setup"}, tgt, 1'b0, 1'b0, 32'd0, 1'b0);
      acc = 0; done = 1'b0;
      while (!done && acc < 40) begin
         @(posedge clk); #1;
         penable = 1'b1;
         if (glitch) paddr = gAddr;
         randomizeResp();
         tRdy = (acc >= waits);
         tout = TO_EN && tgt != 0 && !tRdy && acc == TO - 1;
         if (tgt == 1) begin aPready = tRdy; aPrdata = rd; aPslverr = tRdy & err; end
         if (tgt == 2) begin bPready = tRdy; bPrdata = rd; bPslverr = tRdy & err; end
         #3;
         if (tgt == 0 || tout || tRdy) begin
            checkCycle({nm, " done"}, tout ? 0 : tgt, 1'b1, 1'b1, expRd, expErr);
            done = 1'b1;
         end else begin
            checkCycle({nm, " wait"}, tgt, 1'b1, 1'b0, rd, 1'b0);
         end
         acc++;
      end
      if (!done) begin
         nTests++; nFail++;
         $display("FAIL %s bound: transfer never completed within 40 cycles", nm);
      end
   endtask

   vec_t vecs[$];

   initial begin
      vec_t v;
      rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 32'd0; pwdata = 32'd0;
      randomizeResp();

      // Reset state, and reset must mask a live SETUP toward A.
      #3 checkCycle("reset idle", 0, 1'b0, 1'b0, 32'd0, 1'b0);
      paddr = 32'h0000_0010; psel = 1'b1; aPready = 1'b1;
      #1 checkCycle("reset setupA", 0, 1'b0, 1'b0, 32'd0, 1'b0);
      psel = 1'b0;
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

      vecs.push_back('{32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 0, 32'h0,         1'b0, 1, 1'b0, 32'h0});
      vecs.push_back('{32'h0001_0004, 1'b0, 32'h0,         3, 32'h1234_5678, 1'b0, 2, 1'b0, 32'h1234_5678});
      vecs.push_back('{32'h0005_0000, 1'b0, 32'h0,         0, 32'hAAAA_5555, 1'b0, 0, 1'b1, 32'h0});
      vecs.push_back('{32'h0001_0008, 1'b1, 32'hCAFE_F00D, 0, 32'h0,         1'b1, 2, 1'b1, 32'h0});
      vecs.push_back('{32'h0000_FFFC, 1'b0, 32'h0,         1, 32'h0BAD_F00D, 1'b0, 1, 1'b0, 32'h0BAD_F00D});
      vecs.push_back('{32'h0001_FFFC, 1'b0, 32'h0,         2, 32'h5A5A_A5A5, 1'b1, 2, 1'b1, 32'h5A5A_A5A5});
      vecs.push_back('{32'h0002_0000, 1'b1, 32'h1111_2222, 0, 32'h0,         1'b0, 0, 1'b1, 32'h0});
      vecs.push_back('{32'hFFFF_FFFC, 1'b0, 32'h0,         0, 32'h7777_7777, 1'b0, 0, 1'b1, 32'h0});
      vecs.push_back('{32'h0000_0000, 1'b0, 32'h0,         4, 32'h8765_4321, 1'b1, 1, 1'b1, 32'h8765_4321});

      foreach (vecs[i]) begin
         v = vecs[i];
         doXfer($sformatf("vec%0d", i), v.addr, v.write, v.wdata, v.waits, v.rdata, v.err,
                1'b0, 32'd0, v.expTgt, v.expErr, v.expRdata);
         idleCycle($sformatf("vec%0d idle", i));
      end

      // Back-to-back: A read with address moved into B mid-ACCESS, then B write.
      doXfer("glitchA", 32'h0000_0100, 1'b0, 32'h0, 2, 32'h0A0A_0A0A, 1'b0,
             1'b1, 32'h0001_0000, 1, 1'b0, 32'h0A0A_0A0A);
      doXfer("b2bB", 32'h0001_0000, 1'b1, 32'h0B0B_0B0B, 1, 32'h0, 1'b0,
             1'b0, 32'd0, 2, 1'b0, 32'h0);
      idleCycle("b2b idle");

      // Reset asserted while A is stalled in ACCESS.
      @(posedge clk); #1;
      paddr = 32'h0000_0020; pwrite = 1'b0; psel = 1'b1; penable = 1'b0; aPready = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1; aPready = 1'b0;
      #2 checkCycle("rst pre", 1, 1'b1, 1'b0, aPrdata, aPslverr);
      rst_n = 1'b0;
      #1 checkCycle("rst mid", 0, 1'b0, 1'b0, 32'd0, 1'b0);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
      #3 checkCycle("rst after", 0, 1'b0, 1'b0, 32'd0, 1'b0);
      doXfer("post rst B", 32'h0001_0040, 1'b0, 32'h0, 0, 32'hFACE_0001, 1'b0,
             1'b0, 32'd0, 2, 1'b0, 32'hFACE_0001);
      idleCycle("post rst idle");

      // Long stalls: one just under the limit, one past it.
      doXfer("stall15", 32'h0000_0200, 1'b0, 32'h0, TO - 1, 32'h1515_1515, 1'b0,
             1'b0, 32'd0, 1, 1'b0, 32'h1515_1515);
      idleCycle("stall15 idle");
      if (TO_EN)
         doXfer("stall20", 32'h0000_0300, 1'b0, 32'h0, 20, 32'h2020_2020, 1'b0,
                1'b0, 32'd0, 1, 1'b1, 32'h0);
      else
         doXfer("stall20", 32'h0000_0300, 1'b0, 32'h0, 20, 32'h2020_2020, 1'b0,
                1'b0, 32'd0, 1, 1'b0, 32'h2020_2020);
      idleCycle("stall20 idle");

      // Randomised transfers checked against the range-based model.
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a;
         logic [31:0] rd;
         logic        wr, er;
         int          k, w, t;
         k = $urandom_range(0, 2);
         if (k == 0)      a = {16'h0000, 16'($urandom())};
         else if (k == 1) a = {16'h0001, 16'($urandom())};
         else             a = $urandom() | 32'h0002_0000;
         wr = 1'($urandom_range(0, 1));
         er = 1'($urandom_range(0, 1));
         rd = $urandom();
         w  = $urandom_range(0, 5);
         t  = regionOf(a);
         doXfer($sformatf("rnd%0d", n), a, wr, $urandom(), w, rd, er, 1'b0, 32'd0,
                t, (t == 0) ? 1'b1 : er, (t == 0) ? 32'd0 : rd);
         if ($urandom_range(0, 1) == 0) idleCycle($sformatf("rnd%0d idle", n));
      end
      idleCycle("final idle");

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
